// File: rtl/fp_subtractor_seq.sv
// Multi-cycle IEEE-754 single-precision subtractor (d = a - b) built around one
// 28-bit working mantissa that is shifted a single bit per cycle.
module fp_subtractor_seq #(
  parameter int MAX_ALIGN = 27
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] d,
  output logic        overflow
);

  localparam int DW = $clog2(MAX_ALIGN + 2);

  typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, ROUND, DONE} state_t;

  state_t          state, state_nx;
  logic [27:0]     big_m, small_m;
  logic [9:0]      exp_r;
  logic [DW-1:0]   diff;
  logic            big_s, small_s;

  // Operand unpacking; b's sign is inverted so the datapath only ever adds.
  logic [9:0]      ea, eb, exp_gap;
  logic [27:0]     ma, mb;
  logic            sa, sb, swap;
  logic [DW-1:0]   diff_ld;

  assign ea      = (a[30:23] == 8'd0) ? 10'd1 : {2'b00, a[30:23]};
  assign eb      = (b[30:23] == 8'd0) ? 10'd1 : {2'b00, b[30:23]};
  assign ma      = {1'b0, |a[30:23], a[22:0], 3'b000};
  assign mb      = {1'b0, |b[30:23], b[22:0], 3'b000};
  assign sa      = a[31];
  assign sb      = ~b[31];
  assign swap    = eb > ea;
  assign exp_gap = swap ? (eb - ea) : (ea - eb);
  assign diff_ld = (exp_gap > 10'(MAX_ALIGN + 1)) ? DW'(MAX_ALIGN + 1) : exp_gap[DW-1:0];

  // Signed add of the aligned magnitudes.
  logic            mag_ge;
  logic [27:0]     sum_m;
  logic            sum_s;

  assign mag_ge = big_m >= small_m;
  assign sum_m  = (big_s == small_s) ? (big_m + small_m)
                : (mag_ge ? (big_m - small_m) : (small_m - big_m));
  assign sum_s  = (big_s == small_s) ? big_s : (mag_ge ? big_s : small_s);

  // Round-to-nearest-even on G/R/S with LSB at bit 3; a carry out renormalizes.
  logic            round_up;
  logic [24:0]     rnd;
  logic [23:0]     rnd_mant;
  logic [9:0]      rnd_exp;
  logic            rnd_ovf;
  logic [7:0]      rnd_field;

  assign round_up  = big_m[2] & (big_m[1] | big_m[0] | big_m[3]);
  assign rnd       = {1'b0, big_m[26:3]} + 25'(round_up);
  assign rnd_mant  = rnd[24] ? rnd[24:1] : rnd[23:0];
  assign rnd_exp   = exp_r + 10'(rnd[24]);
  assign rnd_ovf   = rnd_exp >= 10'd255;
  assign rnd_field = rnd_mant[23] ? rnd_exp[7:0] : 8'd0;

  // NOTE: every signal assigned in always_comb gets a default first, so no path
  // through the case can leave it unassigned and infer a latch.
  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = (diff_ld == '0) ? ADD : ALIGN;
      end
      ALIGN: begin
        if (diff > DW'(MAX_ALIGN) || diff == DW'(1)) state_nx = ADD;
      end
      ADD: begin
        state_nx = (sum_m == 28'd0) ? DONE : NORM;
      end
      NORM: begin
        if (big_m[27]) state_nx = ROUND;
        else if (!big_m[26] && exp_r > 10'd1)
          state_nx = (big_m[25] || exp_r == 10'd2) ? ROUND : NORM;
        else state_nx = ROUND;
      end
      ROUND: state_nx = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      big_m    <= '0;
      small_m  <= '0;
      exp_r    <= '0;
      diff     <= '0;
      big_s    <= 1'b0;
      small_s  <= 1'b0;
      d        <= '0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          big_m    <= swap ? mb : ma;
          small_m  <= swap ? ma : mb;
          big_s    <= swap ? sb : sa;
          small_s  <= swap ? sa : sb;
          exp_r    <= swap ? eb : ea;
          diff     <= diff_ld;
          overflow <= 1'b0;
        end
        ALIGN: begin
          if (diff > DW'(MAX_ALIGN)) begin
            // Beyond the cap the whole small operand only contributes sticky.
            small_m <= {27'd0, |small_m};
            diff    <= '0;
          end else begin
            small_m <= {1'b0, small_m[27:2], small_m[1] | small_m[0]};
            diff    <= diff - DW'(1);
          end
        end
        ADD: begin
          big_m <= sum_m;
          big_s <= sum_s;
          if (sum_m == 28'd0) d <= 32'h0000_0000;
        end
        NORM: begin
          if (big_m[27]) begin
            big_m <= {1'b0, big_m[27:2], big_m[1] | big_m[0]};
            exp_r <= exp_r + 10'd1;
          end else if (!big_m[26] && exp_r > 10'd1) begin
            big_m <= {big_m[26:0], 1'b0};
            exp_r <= exp_r - 10'd1;
          end
        end
        ROUND: begin
          overflow <= rnd_ovf;
          d        <= rnd_ovf ? {big_s, 8'hFF, 23'd0}
                              : {big_s, rnd_field, rnd_mant[22:0]};
        end
        default: ;
      endcase
    end
  end

endmodule
